// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between NUM_REQ requesters.
// Latches the winner's request, issues it to memory, and returns the response as a one-cycle pulse.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_vld,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_gnt,
    output logic [NUM_REQ-1:0]               rsp_vld,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             mem_req_vld,
    input  logic                             mem_req_rdy,
    output logic                             mem_req_we,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_WIDTH-1:0]            mem_req_wdata,
    input  logic                             mem_rsp_vld,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    output logic                             busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;

    // Modulo-NUM_REQ addition of two in-range requester indices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s >= SUM_W'(NUM_REQ)) begin
            s = s - SUM_W'(NUM_REQ);
        end
        return PTR_W'(s);
    endfunction

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          rr_ptr_nxt;
    logic [PTR_W-1:0]          owner;
    logic [PTR_W-1:0]          owner_nxt;
    logic [NUM_REQ-1:0]        req_gnt_nxt;
    logic [NUM_REQ-1:0]        rsp_vld_nxt;
    logic [DATA_WIDTH-1:0]     rsp_data_nxt;
    logic                      mem_req_vld_nxt;
    logic                      mem_req_we_nxt;
    logic [ADDR_WIDTH-1:0]     mem_req_addr_nxt;
    logic [DATA_WIDTH-1:0]     mem_req_wdata_nxt;
    logic                      busy_nxt;

    logic [2*NUM_REQ-1:0]      req_dbl;
    logic [NUM_REQ-1:0]        req_rot;
    logic [PTR_W-1:0]          rot_idx;
    logic [PTR_W-1:0]          winner;

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    assign req_dbl = {req_vld, req_vld};
    assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

    always_comb begin
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = PTR_W'(i);
            end
        end
    end

    assign winner = ptr_add(rr_ptr, rot_idx);

    // Next-state and registered-output values.
    always_comb begin
        state_nxt         = state;
        rr_ptr_nxt        = rr_ptr;
        owner_nxt         = owner;
        req_gnt_nxt       = '0;
        rsp_vld_nxt       = '0;
        rsp_data_nxt      = rsp_data;
        mem_req_vld_nxt   = mem_req_vld;
        mem_req_we_nxt    = mem_req_we;
        mem_req_addr_nxt  = mem_req_addr;
        mem_req_wdata_nxt = mem_req_wdata;

        case (state)
            ST_IDLE: begin
                if (|req_vld) begin
                    owner_nxt         = winner;
                    req_gnt_nxt       = NUM_REQ'(1) << winner;
                    mem_req_vld_nxt   = 1'b1;
                    mem_req_we_nxt    = req_we[winner];
                    mem_req_addr_nxt  = ADDR_WIDTH'(req_addr >> (32'(winner) * ADDR_WIDTH));
                    mem_req_wdata_nxt = DATA_WIDTH'(req_wdata >> (32'(winner) * DATA_WIDTH));
                    state_nxt         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_rdy) begin
                    mem_req_vld_nxt = 1'b0;
                    state_nxt       = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_vld) begin
                    rsp_data_nxt = mem_rsp_data;
                    rsp_vld_nxt  = NUM_REQ'(1) << owner;
                    rr_ptr_nxt   = ptr_add(owner, PTR_W'(1));
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                mem_req_vld_nxt = 1'b0;
                state_nxt       = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            req_gnt       <= '0;
            rsp_vld       <= '0;
            rsp_data      <= '0;
            mem_req_vld   <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            owner         <= owner_nxt;
            req_gnt       <= req_gnt_nxt;
            rsp_vld       <= rsp_vld_nxt;
            rsp_data      <= rsp_data_nxt;
            mem_req_vld   <= mem_req_vld_nxt;
            mem_req_we    <= mem_req_we_nxt;
            mem_req_addr  <= mem_req_addr_nxt;
            mem_req_wdata <= mem_req_wdata_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_gnt;
    logic [3:0]  rsp_vld;
    logic [15:0] rsp_data;
    logic        mem_req_vld;
    logic        mem_req_rdy;
    logic        mem_req_we;
    logic [7:0]  mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_rsp_vld;
    logic [15:0] mem_rsp_data;
    logic        busy;

    int vecs = 0;
    int miscompares = 0;
    int mdl_ptr = 0;

    mem_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_vld       (req_vld),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_gnt       (req_gnt),
        .rsp_vld       (rsp_vld),
        .rsp_data      (rsp_data),
        .mem_req_vld   (mem_req_vld),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_vld   (mem_rsp_vld),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requesting index scanning from the pointer, wrapping around.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int off = 0; off < 4; off++) begin
            if (v[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] vld, input logic [3:0] we, input logic [31:0] addr,
                           input logic [63:0] wdata, input int rdy_gap, input int rsp_gap,
                           input logic [15:0] rdata, input bit spur, output logic [3:0] gnt_seen);
        int w;
        logic [3:0]  oh;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        ew;
        w  = pick(vld, mdl_ptr);
        oh = 4'b0001 << w;
        ea = addr[w*8 +: 8];
        ed = wdata[w*16 +: 16];
        ew = we[w];
        chk("idle_busy", busy, 0);
        req_vld = vld; req_we = we; req_addr = addr; req_wdata = wdata;
        step();
        gnt_seen = req_gnt;
        chk("gnt", req_gnt, oh);
        chk("issue_vld", mem_req_vld, 1);
        chk("issue_addr", mem_req_addr, ea);
        chk("issue_we", mem_req_we, ew);
        chk("issue_wdata", mem_req_wdata, ed);
        chk("issue_busy", busy, 1);
        req_vld = '0;
        req_we = 4'($urandom);
        req_addr = $urandom;
        req_wdata = {$urandom, $urandom};
        for (int i = 0; i < rdy_gap; i++) begin
            mem_req_rdy = 1'b0;
            mem_rsp_vld = spur && (i == 0);
            mem_rsp_data = 16'hdead;
            step();
            chk("hold_vld", mem_req_vld, 1);
            chk("hold_addr", mem_req_addr, ea);
            chk("hold_we", mem_req_we, ew);
            chk("hold_wdata", mem_req_wdata, ed);
            chk("hold_gnt", req_gnt, 0);
            chk("hold_rsp", rsp_vld, 0);
        end
        mem_rsp_vld = 1'b0;
        mem_req_rdy = 1'b1;
        step();
        mem_req_rdy = 1'b0;
        chk("accept_vld", mem_req_vld, 0);
        chk("wait_busy", busy, 1);
        chk("wait_rsp", rsp_vld, 0);
        for (int i = 0; i < rsp_gap; i++) begin
            step();
            chk("wait_rsp", rsp_vld, 0);
            chk("wait_busy", busy, 1);
        end
        mem_rsp_vld = 1'b1;
        mem_rsp_data = rdata;
        step();
        mem_rsp_vld = 1'b0;
        chk("rsp_vld", rsp_vld, oh);
        chk("rsp_data", rsp_data, rdata);
        chk("done_busy", busy, 0);
        chk("done_gnt", req_gnt, 0);
        mdl_ptr = (w + 1) % 4;
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] vld_r;
        int order [5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req_vld = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = '0;
        #12;
        chk("rst_gnt", req_gnt, 0);
        chk("rst_rsp", rsp_vld, 0);
        chk("rst_mvld", mem_req_vld, 0);
        chk("rst_we", mem_req_we, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_wdata", mem_req_wdata, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // All four requesters asserting: grant order 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b1111, 4'b0000, $urandom, {$urandom, $urandom}, 0, 0, 16'($urandom), 1'b0, g);
            chk("rr_order", g, 4'b0001 << order[n]);
        end

        // Single read from requester 1, answered three cycles after accept.
        run_txn(4'b0010, 4'b0000, 32'h00003A00, 64'h0, 0, 2, 16'hBEEF, 1'b0, g);
        step();
        chk("rsp_data_hold", rsp_data, 16'hBEEF);
        chk("rsp_pulse_one", rsp_vld, 0);

        // Write from requester 3.
        run_txn(4'b1000, 4'b1000, 32'h10000000, 64'h1234_0000_0000_0000, 1, 1, 16'h0077, 1'b0, g);

        // Spurious response in IDLE, then in ISSUE.
        mem_rsp_vld = 1'b1; mem_rsp_data = 16'hAAAA;
        step();
        mem_rsp_vld = 1'b0;
        chk("spur_idle_rsp", rsp_vld, 0);
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_data", rsp_data, 16'h0077);
        run_txn(4'b0101, 4'b0001, $urandom, {$urandom, $urandom}, 2, 0, 16'h5555, 1'b1, g);

        // Backpressure for five cycles.
        run_txn(4'b0110, 4'b0100, $urandom, {$urandom, $urandom}, 5, 1, 16'h1111, 1'b0, g);

        // Reset in WAIT_RSP; pointer returns to 0.
        run_txn(4'b0100, 4'b0000, $urandom, {$urandom, $urandom}, 0, 0, 16'h2222, 1'b0, g);
        req_vld = 4'b0001; req_addr = 32'h0000_0042;
        step();
        chk("pre_rst_gnt", req_gnt, 4'b0001 << pick(4'b0001, mdl_ptr));
        req_vld = '0; mem_req_rdy = 1'b1;
        step();
        mem_req_rdy = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mvld", mem_req_vld, 0);
        chk("mid_rst_addr", mem_req_addr, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_rsp", rsp_vld, 0);
        #2 rst_n = 1'b1;
        mdl_ptr = 0;
        step();
        mem_rsp_vld = 1'b1; mem_rsp_data = 16'h9999;
        step();
        mem_rsp_vld = 1'b0;
        chk("late_rsp", rsp_vld, 0);
        chk("late_busy", busy, 0);
        run_txn(4'b1010, 4'b0000, $urandom, {$urandom, $urandom}, 0, 0, 16'h3333, 1'b0, g);
        chk("post_rst_ptr", g, 4'b0010);

        // Randomized transactions against the model.
        for (int n = 0; n < 30; n++) begin
            vld_r = 4'($urandom_range(1, 15));
            run_txn(vld_r, 4'($urandom), $urandom, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                    1'($urandom), g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
